// File: rtl/dct_row_seq.sv
// ============================================================================
// dct_row_seq : streams ROWS-row blocks through the 1-D DCT core, 2-stage pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module dct_row_seq #(
  parameter int ROWS  = 8,
  parameter int IN_W  = 64,
  parameter int OUT_W = 144
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_W-1:0]          s_data,
  output logic [IN_W-1:0]          core_x,
  input  logic [OUT_W-1:0]         core_y,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic [$clog2(ROWS)-1:0]  m_row,
  output logic                     m_last,
  output logic                     busy,
  output logic                     blk_done,
  output logic [15:0]              blk_cnt
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] C_LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_v1;
  logic              r_v2;
  logic [IN_W-1:0]   r_x;
  logic [OUT_W-1:0]  r_y;
  logic [RW-1:0]     r_row1;
  logic [RW-1:0]     r_row2;
  logic [RW-1:0]     r_in_row;
  logic [15:0]       r_blk_cnt;
  logic              r_blk_done;

  logic w_accept;
  logic w_adv;
  logic w_out_hs;
  logic w_last_hs;

  // s_ready looks straight through to m_ready so a full pipe still streams
  assign s_ready   = !clr && (!r_v1 || !r_v2 || m_ready);
  assign w_accept  = s_valid && s_ready;
  assign w_adv     = r_v1 && (!r_v2 || m_ready);
  assign w_out_hs  = r_v2 && m_ready;
  assign w_last_hs = w_out_hs && (r_row2 == C_LAST_ROW);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_accept && (r_in_row == C_LAST_ROW)) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // a row of the next block may already sit in stage 1 or arrive now
        if (w_last_hs) begin
          if (w_accept && (r_in_row == C_LAST_ROW)) w_state_nxt = S_DRAIN;
          else if (w_accept || r_v1)                 w_state_nxt = S_ACTIVE;
          else                                       w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (clr) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_row1     <= '0;
      r_row2     <= '0;
      r_in_row   <= '0;
      r_blk_cnt  <= '0;
      r_blk_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_blk_done <= !clr && w_last_hs;
      if (clr) begin
        r_v1      <= 1'b0;
        r_v2      <= 1'b0;
        r_in_row  <= '0;
        r_blk_cnt <= '0;
      end else begin
        if (w_accept) begin
          r_v1     <= 1'b1;
          r_x      <= s_data;
          r_row1   <= r_in_row;
          r_in_row <= r_in_row + RW'(1);
        end else if (w_adv) begin
          r_v1 <= 1'b0;
        end
        // core_y is only captured here, so X on it at other times is harmless
        if (w_adv) begin
          r_v2   <= 1'b1;
          r_y    <= core_y;
          r_row2 <= r_row1;
        end else if (w_out_hs) begin
          r_v2 <= 1'b0;
        end
        if (w_last_hs) r_blk_cnt <= r_blk_cnt + 16'd1;
      end
    end
  end

  assign core_x   = r_x;
  assign m_valid  = r_v2;
  assign m_data   = r_y;
  assign m_row    = r_row2;
  assign m_last   = r_v2 && (r_row2 == C_LAST_ROW);
  assign busy     = (r_state != S_IDLE);
  assign blk_done = r_blk_done;
  assign blk_cnt  = r_blk_cnt;

endmodule

`default_nettype wire

// File: doc/dct_row_seq.md
Name: dct_row_seq

Overview:
- Sequencer that streams 8-row blocks through the shared combinational 1-D DCT-II core (64-bit row in, 144-bit coefficient row out).
- Registers the core input and output, giving a 2-stage valid/ready pipeline with full backpressure.
- Tags each output row with its index and marks the last row of each block.
- Sits between the block source (sample fetch) and the transpose buffer of the future 2-D DCT.

Parameters:
- ROWS, 8, rows per block; power of two, 2..16.
- IN_W, 64, packed input row width (8 x 8-bit samples).
- OUT_W, 144, packed coefficient row width (8 x 18-bit).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush: empties the pipeline and zeroes counters.
- s_valid  input  1  input row valid.
- s_ready  output  1  input row accepted when s_valid & s_ready.
- s_data  input  IN_W  input row.
- core_x  output  IN_W  drives core X; equals stage-1 register.
- core_y  input  OUT_W  core Y; combinational function of core_x.
- m_valid  output  1  output row valid.
- m_ready  input  1  downstream ready.
- m_data  output  OUT_W  coefficient row (stage-2 register).
- m_row  output  log2(ROWS)  row index of m_data within its block.
- m_last  output  1  high when m_row == ROWS-1 and m_valid.
- busy  output  1  high in state ACTIVE or DRAIN.
- blk_done  output  1  one-cycle pulse when the last row of a block is handshaken out.
- blk_cnt  output  16  completed blocks; wraps 65535 -> 0.

Behaviour:
- Reset (rst_n low, asynchronous, at any time including mid-block): all registers cleared.
  - Outputs: s_ready=1, core_x=0, m_valid=0, m_data=0, m_row=0, m_last=0, busy=0, blk_done=0, blk_cnt=0; state=IDLE.
  - Any rows in flight are discarded.
- Stage 1 (v1, x_reg, row1):
  - Loads s_data and in_row on accept.
  - Advances when v1 & (!v2 | m_ready).
  - Clears v1 when it advances with no new accept.
- Stage 2 (v2, y_reg, row2):
  - Loads core_y and row1 when stage 1 advances.
  - Clears when m_valid & m_ready with no advance.
- s_ready = !v1 | (!v2 | m_ready). This is a combinational path from m_ready.
- Latency: row accepted at edge t -> m_valid high after edge t+1 (2 edges) with no stall. Throughput 1 row/cycle.
- m_valid = v2. m_data and m_row hold stable while m_valid & !m_ready.
- in_row:
  - Increments on each accept; wraps ROWS-1 -> 0.
  - out_row is carried with the data, never recomputed.
- State machine:
  - IDLE -> ACTIVE on first accept.
  - ACTIVE -> DRAIN on accept with in_row == ROWS-1.
  - DRAIN -> IDLE on the handshake of the m_last row, unless another row was already accepted (then -> ACTIVE).
  - A new block may begin entering while the previous block drains; rows never mix indices.
- blk_done and the blk_cnt increment occur at the m_last handshake edge.
- Simultaneous accept and output handshake in the same cycle: both take effect; no bubble.
- clr has priority over every other input:
  - Next edge: v1=v2=0, in_row=0, state=IDLE, blk_cnt=0.
  - s_ready is forced low in the clr cycle.
  - The output handshake in the clr cycle is ignored (no blk_done).
- core_y is sampled only when stage 1 advances; X/Z on core_y at other times must not propagate.

Test Plan:
- Bench uses a stub core with core_y = {80'b0, core_x}.
- Streaming, m_ready=1: 8 rows s_data=1..8 back-to-back -> m_data = 1..8 with m_row 0..7 on consecutive cycles, first output 2 edges after first accept; m_last and blk_done on row 7; blk_cnt=1.
- Backpressure: m_ready low for 5 cycles after row 2 is output -> m_data holds 3, s_ready drops once both stages are full, no row lost or duplicated; final sequence 1..8.
- Back-to-back blocks: 16 rows with random s_valid gaps and random m_ready -> two m_last pulses, m_row wraps 7 -> 0, blk_cnt=2, busy low only after the final handshake.
- Async reset mid-block: rst_n low after 3 rows accepted -> immediately m_valid=0, blk_cnt=0, s_ready=1; a fresh block then starts at m_row=0.
- clr with both stages full and m_ready=1: no handshake counted; next edge m_valid=0, state IDLE, blk_done never pulses.
- Wrap: force 65535 completed blocks (or a preload hook in the bench) -> the next block makes blk_cnt=0.
